// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector bank: per-channel mode encodings
// and the mode-to-event selection helper.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_sel(input logic [1:0] mode, input logic rise, input logic fall);
        logic ev;
        ev = 1'b0;
        case (edge_mode_e'(mode))
            MODE_RISE: ev = rise;
            MODE_FALL: ev = fall;
            MODE_BOTH: ev = rise | fall;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, edge select, pulse, sticky pending
// and, when EDGE_COUNT_EN is defined, a saturating event counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             pulse,
    output logic             pending,
    output logic             pending_nxt_c,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   ev_c;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Event is suppressed while the top-level warm-up window is open.
    always_comb begin
        ev_c = 1'b0;
        if (en) begin
            ev_c = edge_sel(mode, sync_out & ~prev_q, ~sync_out & prev_q);
        end
    end

    // A coincident event wins over clear, so the flag stays set.
    assign pending_nxt_c = ev_c | (pending & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q  <= SYNC_STAGES'({sync_q, din});
            prev_q  <= sync_out;
            pulse   <= ev_c;
            pending <= pending_nxt_c;
        end
    end

`ifdef EDGE_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Clear with a coincident event restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= CNT_W'(ev_c);
        end else if (ev_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;
`else
    assign count = '0;
`endif

endmodule

// File: rtl/edge_detect_bank.sv
// Multi-channel edge detector bank with warm-up masking and registered irq.
// Optional per-channel event counters are built when EDGE_COUNT_EN is defined.
module edge_detect_bank
    import edge_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       signal,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       pulse,
    output logic [CH-1:0]       pending,
    output logic                irq,
    output logic [CH*CNT_W-1:0] count
);

    localparam int unsigned WU_MAX = SYNC_STAGES + 1;
    localparam int unsigned WU_W   = $clog2(WU_MAX + 1);

    logic [WU_W-1:0] wu_q;
    logic            en_c;
    logic [CH-1:0]   pend_nxt;

    assign en_c = (wu_q == WU_W'(WU_MAX));

    // Warm-up counter: holds events off until the sync chain and prev have
    // been refilled with post-reset samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            wu_q <= '0;
        end else if (!en_c) begin
            wu_q <= wu_q + WU_W'(1);
        end
    end

    // irq follows next-state pending so it rises on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend_nxt;
        end
    end

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .en            (en_c),
            .din           (signal[i]),
            .mode          (mode[2*i +: 2]),
            .clr           (clr[i]),
            .pulse         (pulse[i]),
            .pending       (pending[i]),
            .pending_nxt_c (pend_nxt[i]),
            .count         (count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Scoreboard bench for edge_detect_bank: stimulus pushes expected outputs from
// a sample-history reference model, a monitor pops and compares every cycle.
module tb_edge_detect_bank;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef EDGE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [CH-1:0]    pulse;
        logic [CH-1:0]    pending;
        logic             irq;
        logic [CH*CW-1:0] count;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     signal;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     clr;
    logic [CH-1:0]     pulse;
    logic [CH-1:0]     pending;
    logic              irq;
    logic [CH*CW-1:0]  count;

    edge_detect_bank #(.CH(CH), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .signal  (signal),
        .mode    (mode),
        .clr     (clr),
        .pulse   (pulse),
        .pending (pending),
        .irq     (irq),
        .count   (count)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    logic [CH-1:0] hist[$];
    int            k = 0;
    int            k_rst = 0;
    logic [CH-1:0] m_pend = '0;
    int            m_cnt[CH];
    int            checks = 0;
    int            errors = 0;

    // Reference: an event at edge k is the transition between the input
    // samples taken S+1 and S edges earlier, and only once S+2 edges have
    // passed since the last reset edge.
    task automatic step(input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                        input logic [CH-1:0] c, input logic r);
        exp_t x;
        logic e, a, b;
        @(negedge clk);
        signal = s; mode = m; clr = c; rst = r;
        hist.push_back(s);
        x = '0;
        if (r) begin
            k_rst  = k;
            m_pend = '0;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                e = 1'b0;
                if (k >= k_rst + S + 2) begin
                    a = hist[k-S][i];
                    b = hist[k-S-1][i];
                    case (int'(m[2*i +: 2]))
                        1: e = a && !b;
                        2: e = !a && b;
                        3: e = (a != b);
                        default: e = 1'b0;
                    endcase
                end
                x.pulse[i] = e;
                if (e) m_pend[i] = 1'b1;
                else if (c[i]) m_pend[i] = 1'b0;
                if (c[i]) m_cnt[i] = e ? 1 : 0;
                else if (e && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        x.pending = m_pend;
        x.irq     = |m_pend;
        for (int i = 0; i < CH; i++)
            x.count[i*CW +: CW] = CNT_ON ? CW'(m_cnt[i]) : '0;
        q.push_back(x);
        k++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, k, got, want);
        end
    endtask

    // Monitor: compares each registered output set just after its edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("pulse",   32'(pulse),   32'(x.pulse));
                check("pending", 32'(pending), 32'(x.pending));
                check("irq",     32'(irq),     32'(x.irq));
                check("count",   32'(count),   32'(x.count));
            end
        end
    end

    initial begin
        logic [CH-1:0]   sv;
        logic [2*CH-1:0] mv;
        logic [CH-1:0]   cv;
        rst = 1'b1; signal = '0; mode = '0; clr = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;

        // Reset and idle
        step(4'h0, 8'h00, 4'h0, 1'b1);
        step(4'h0, 8'h00, 4'h0, 1'b1);
        repeat (6) step(4'h0, 8'h00, 4'h0, 1'b0);
        // ch0 rise
        repeat (4) step(4'h1, 8'h01, 4'h0, 1'b0);
        step(4'h1, 8'h01, 4'h1, 1'b0);
        // ch1 fall only, then both
        for (int pass = 0; pass < 2; pass++) begin
            mv = (pass == 0) ? 8'h08 : 8'h0C;
            repeat (3) step(4'h2, mv, 4'h0, 1'b0);
            repeat (3) step(4'h0, mv, 4'h0, 1'b0);
            repeat (4) step(4'h2, mv, 4'h0, 1'b0);
            step(4'h0, mv, 4'h2, 1'b0);
        end
        // Level held high through reset
        step(4'hF, 8'hFF, 4'h0, 1'b1);
        step(4'hF, 8'hFF, 4'h0, 1'b1);
        repeat (10) step(4'hF, 8'hFF, 4'h0, 1'b0);
        step(4'h0, 8'h00, 4'hF, 1'b1);
        repeat (5) step(4'h0, 8'h00, 4'h0, 1'b0);
        // ch2 saturation with clear coincident with the sixth event
        for (int n = 0; n < 6; n++) begin
            step(4'h4, 8'h10, 4'h0, 1'b0);
            step(4'h4, 8'h10, 4'h0, 1'b0);
            step(4'h0, 8'h10, (n == 5) ? 4'h4 : 4'h0, 1'b0);
            step(4'h0, 8'h10, 4'h0, 1'b0);
        end
        // ch3 off while toggling, then rise mode
        repeat (3) step(4'h8, 8'h00, 4'h0, 1'b0);
        repeat (3) step(4'h0, 8'h00, 4'h0, 1'b0);
        step(4'h0, 8'h40, 4'h0, 1'b0);
        repeat (4) step(4'h8, 8'h40, 4'h0, 1'b0);
        // Reset one cycle after an edge enters the chain
        step(4'h0, 8'hFF, 4'hF, 1'b0);
        repeat (3) step(4'h0, 8'hFF, 4'h0, 1'b0);
        step(4'hF, 8'hFF, 4'h0, 1'b0);
        step(4'hF, 8'hFF, 4'h0, 1'b1);
        repeat (8) step(4'hF, 8'hFF, 4'h0, 1'b0);

        // Random phase
        sv = '0; mv = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(3) == 0) sv[i] = ~sv[i];
                cv[i] = ($urandom_range(15) == 0);
            end
            if ($urandom_range(15) == 0) mv = 8'($urandom);
            step(sv, mv, cv, ($urandom_range(199) == 0));
        end
        repeat (3) step(sv, mv, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_detect_bank.md
# edge_detect_bank

Parametrised multi-channel edge detector, successor to the single-channel falling-edge pulser. Each channel synchronises an asynchronous input, detects rising, falling or both edges per a runtime mode, and emits a registered one-cycle pulse plus a sticky pending flag. The block sits between external or cross-domain status lines and the control logic or interrupt aggregation that consumes edge events.

## Interface
- CH, 4, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (1..4)
- CNT_W, 8, width of each per-channel event counter (1..16)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- signal  in  CH  raw input levels, may be asynchronous to clk
- mode  in  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clr  in  CH  per-channel clear of pending and count
- pulse  out  CH  registered one-cycle edge pulse
- pending  out  CH  sticky edge flag
- irq  out  1  OR of all pending bits, registered
- count  out  CH*CNT_W  per-channel saturating event count, channel i at [(i+1)*CNT_W-1:i*CNT_W]

## Operation
- Per channel: signal passes through SYNC_STAGES flops (sync_out = last stage); prev flop holds sync_out delayed one cycle.
- Event e: rise = sync_out & ~prev; fall = ~sync_out & prev; e selected by mode; mode 00 gives e = 0. mode is sampled combinationally each cycle, so a change applies to the next evaluation; no registered copy.
- Warm-up: after rst deasserts, e is masked for SYNC_STAGES+1 cycles while the chain fills; a level held high through reset produces no pulse. Genuine edges inside the window are lost by design.
- pulse[i] <= e. A toggle every cycle yields pulse high on consecutive cycles in mode 11.
- pending[i]: set on e, cleared by clr[i]; simultaneous e and clr: pending stays 1.
- count[i]: +1 on e, saturates at 2^CNT_W-1 (no wrap); clr[i] zeroes it; simultaneous e and clr: count becomes 1.
- irq <= |pending (next-state values), so irq rises the same cycle pending does.
- Reset values: sync chain, prev, pulse, pending, irq, count all 0; warm-up counter restarted. Reset mid-operation discards all in-flight edges.

## Timing
- Input change first sampled at edge 0 -> pulse high from edge SYNC_STAGES for exactly one cycle; pending and irq set at the same edge.
- clr at edge k -> pending 0 from edge k; irq falls the same edge if no other channel pending.
- Pulses narrower than one clk period may be missed; no pulse stretching.
- No backpressure; outputs are free-running status.

## Configuration
- EDGE_COUNT_EN defined: per-channel counters built as above.
- Not defined: no counter flops, count tied to all zeros; pulse, pending, irq unchanged.

## Structure
- Package edge_pkg: mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
- Sub-module edge_chan: one channel (sync chain, prev, event select, pulse, pending, optional counter), SYNC_STAGES and CNT_W parameters, enable input from the top-level warm-up logic. Top instantiates CH copies via generate, owns the warm-up counter and irq.

## Test plan
- CH=4, SYNC_STAGES=2, ch0 mode 01, signal[0] 0->1 sampled at edge 10 -> pulse[0] high edge 12 only, pending[0]=1, irq=1, count[0]=1.
- ch1 mode 10, signal[1] toggles 1->0->1 -> one pulse on the falling edge only; mode 11 same stimulus -> two pulses, count[1]=2.
- signal=4'hF held through reset and after release -> no pulse, pending=0, count=0 for 10 cycles.
- CNT_W=2, ch2 mode 01, 5 rising edges -> count[2] stops at 3; clr[2] coincident with 6th edge -> count[2]=1, pending[2]=1.
- ch3 mode 00, signal toggled -> no pulse; mode switched to 01 before next rise -> pulse on that rise.
- rst asserted 1 cycle after an input edge enters the chain -> no pulse after release; EDGE_COUNT_EN undefined build -> count=0 throughout all above.
